// File: rtl/rvsp_core_multiciclo.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB over shared ALU and regfile.
// Optional debug probes are enabled by defining RVSP_DEBUG_PORTS_EN.
module rvsp_core_multiciclo #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              ADDR_W   = 32,
    parameter longint unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ready,
    output logic              halted,
    output logic              retire
`ifdef RVSP_DEBUG_PORTS_EN
    ,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [31:0]       dbg_ir,
    output logic [2:0]        dbg_state,
    output logic [XLEN-1:0]   dbg_alu_res,
    output logic              dbg_wb_en,
    output logic [4:0]        dbg_wb_idx,
    output logic [XLEN-1:0]   dbg_wb_data
`endif
);

    localparam int IW  = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int SHW = $clog2(XLEN);
    localparam logic [5:0] NR = 6'(NREGS);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t state, state_d;

    logic              run;
    logic [ADDR_W-1:0] pc, pc_d, pc_add, target, jt;
    logic [31:0]       ir, imm32;
    logic [XLEN-1:0]   a, b, imm, alu_q, mdr;
    logic [XLEN-1:0]   imm_d, b_op, alu_res, exe_res, rf_wd;
    logic [XLEN-1:0]   rf [NREGS];
    logic [SHW-1:0]    sh;

    logic [6:0] opcode, f7;
    logic [2:0] f3, alu_f3;
    logic [4:0] rd, rs1, rs2;

    logic is_op, is_opi, is_lw, is_sw, is_br;
    logic is_jal, is_jalr, is_lui, is_auipc;
    logic uses_rd, uses_rs1, uses_rs2, legal;
    logic alu_alt, br_taken, eq, lt, ltu;
    logic ir_we, dec_we, exe_we, mdr_we, pc_we, rf_we;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    always_comb begin
        is_op    = 1'b0;
        is_opi   = 1'b0;
        is_lw    = opcode == 7'b0000011 && f3 == 3'b010;
        is_sw    = opcode == 7'b0100011 && f3 == 3'b010;
        is_br    = opcode == 7'b1100011 && f3 != 3'b010 && f3 != 3'b011;
        is_jal   = opcode == 7'b1101111;
        is_jalr  = opcode == 7'b1100111 && f3 == 3'b000;
        is_lui   = opcode == 7'b0110111;
        is_auipc = opcode == 7'b0010111;
        if (opcode == 7'b0110011) begin
            is_op = f7 == 7'b0000000 ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        end
        if (opcode == 7'b0010011) begin
            unique case (f3)
                3'b001:  is_opi = f7 == 7'b0000000;
                3'b011:  is_opi = 1'b0;
                3'b101:  is_opi = f7 == 7'b0000000 || f7 == 7'b0100000;
                default: is_opi = 1'b1;
            endcase
        end
        uses_rd  = is_op | is_opi | is_lw | is_lui | is_auipc | is_jal | is_jalr;
        uses_rs1 = is_op | is_opi | is_lw | is_sw | is_br | is_jalr;
        uses_rs2 = is_op | is_sw | is_br;
        // ECALL/EBREAK are not in this set, so they halt with the illegals
        legal = (uses_rd | uses_rs1 | is_sw | is_br) &&
                (!uses_rd  || {1'b0, rd}  < NR) &&
                (!uses_rs1 || {1'b0, rs1} < NR) &&
                (!uses_rs2 || {1'b0, rs2} < NR);
    end

    always_comb begin
        imm32 = {{20{ir[31]}}, ir[31:20]};
        unique case (1'b1)
            is_sw:            imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            is_br:            imm32 = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            is_lui, is_auipc: imm32 = {ir[31:12], 12'b0};
            is_jal:           imm32 = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            default: ;
        endcase
    end

    assign imm_d  = XLEN'($signed(imm32));
    assign pc_add = pc + ((state == DECODE) ? ADDR_W'(imm_d) : ADDR_W'(4));

    assign b_op    = (is_op || is_br) ? b : imm;
    assign sh      = b_op[SHW-1:0];
    assign alu_f3  = (is_op || is_opi) ? f3 : 3'b000;
    assign alu_alt = (is_op || (is_opi && f3 == 3'b101)) ? f7[5] : 1'b0;

    always_comb begin
        unique case (alu_f3)
            3'b000: alu_res = alu_alt ? a - b_op : a + b_op;
            3'b001: alu_res = a << sh;
            3'b010: alu_res = XLEN'($signed(a) < $signed(b_op));
            3'b011: alu_res = XLEN'(a < b_op);
            3'b100: alu_res = a ^ b_op;
            3'b101: alu_res = alu_alt ? XLEN'($signed(a) >>> sh) : a >> sh;
            3'b110: alu_res = a | b_op;
            3'b111: alu_res = a & b_op;
        endcase
    end

    assign eq  = a == b;
    assign lt  = $signed(a) < $signed(b);
    assign ltu = a < b;

    always_comb begin
        br_taken = 1'b0;
        unique case (f3)
            3'b000:  br_taken = eq;
            3'b001:  br_taken = !eq;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = !lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = !ltu;
            default: br_taken = 1'b0;
        endcase
    end

    assign jt = is_jalr ? (ADDR_W'(alu_res) & ~ADDR_W'(1)) : target;

    always_comb begin
        exe_res = alu_res;
        if (is_lui)   exe_res = imm;
        if (is_auipc) exe_res = XLEN'(target);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_d;
    end

    always_comb begin
        state_d  = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        halted   = 1'b0;
        retire   = 1'b0;
        ir_we    = 1'b0;
        dec_we   = 1'b0;
        exe_we   = 1'b0;
        mdr_we   = 1'b0;
        pc_we    = 1'b0;
        pc_d     = pc_add;
        rf_we    = 1'b0;
        rf_wd    = alu_q;
        unique case (state)
            FETCH: begin
                imem_req = run;
                if (run && imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                dec_we  = 1'b1;
                state_d = legal ? EXEC : HALT;
            end
            EXEC: begin
                unique case (1'b1)
                    is_br: begin
                        if (br_taken && target[1]) begin
                            state_d = HALT;
                        end else begin
                            pc_we   = 1'b1;
                            pc_d    = br_taken ? target : pc_add;
                            retire  = 1'b1;
                            state_d = FETCH;
                        end
                    end
                    is_jal, is_jalr: begin
                        if (jt[1]) begin
                            state_d = HALT;
                        end else begin
                            pc_we   = 1'b1;
                            pc_d    = jt;
                            rf_we   = 1'b1;
                            rf_wd   = XLEN'(pc_add);
                            retire  = 1'b1;
                            state_d = FETCH;
                        end
                    end
                    is_lw, is_sw: begin
                        if (alu_res[1:0] != 2'b00) begin
                            state_d = HALT;
                        end else begin
                            exe_we  = 1'b1;
                            state_d = MEM;
                        end
                    end
                    default: begin
                        exe_we  = 1'b1;
                        state_d = WB;
                    end
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ready) begin
                    if (is_sw) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we   = 1'b1;
                rf_wd   = is_lw ? mdr : alu_q;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT: halted = 1'b1;
            default: state_d = HALT;
        endcase
    end

    // run holds off the first fetch request until the cycle after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run    <= 1'b0;
            pc     <= ADDR_W'(RESET_PC);
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            imm    <= '0;
            target <= '0;
            alu_q  <= '0;
            mdr    <= '0;
        end else begin
            run <= 1'b1;
            if (ir_we) ir <= imem_rdata;
            if (dec_we) begin
                a      <= rf[rs1[IW-1:0]];
                b      <= rf[rs2[IW-1:0]];
                imm    <= imm_d;
                target <= pc_add;
            end
            if (exe_we) alu_q <= exe_res;
            if (mdr_we) mdr <= dmem_rdata;
            if (pc_we)  pc <= pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (rf_we && rd != 5'd0) begin
            rf[rd[IW-1:0]] <= rf_wd;
        end
    end

    assign imem_addr  = pc;
    assign dmem_addr  = ADDR_W'(alu_q);
    assign dmem_wdata = b;

`ifdef RVSP_DEBUG_PORTS_EN
    assign dbg_pc      = pc;
    assign dbg_ir      = ir;
    assign dbg_state   = state;
    assign dbg_alu_res = alu_res;
    assign dbg_wb_en   = rf_we && rd != 5'd0;
    assign dbg_wb_idx  = rd;
    assign dbg_wb_data = rf_wd;
`endif

endmodule

// File: tb/tb_rvsp_core_multiciclo.sv
// Directed bench for rvsp_core_multiciclo: program runs against wait-state memory models.
`timescale 1ns/1ps
module tb_rvsp_core_multiciclo;

    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        halted, retire;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:63];
    int          dwait = 2;
    int          dcnt = 0;
    int          cyc = 0;
    int          dreq_cnt = 0;
    int          rt_q[$];
    logic [63:0] st_q[$];
    int          ntest = 0;
    int          nfail = 0;

    rvsp_core_multiciclo #(
        .XLEN(32), .NREGS(32), .ADDR_W(32), .RESET_PC(32'h100)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .halted(halted), .retire(retire)
    );

    always #5 clk = ~clk;

    assign imem_ready = imem_req;
    assign imem_rdata = imem[imem_addr[9:2]];
    assign dmem_ready = dmem_req && (dcnt >= dwait);
    assign dmem_rdata = dmem[dmem_addr[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (retire) rt_q.push_back(cyc);
        if (dmem_req) dreq_cnt <= dreq_cnt + 1;
        if (dmem_req && dmem_we && dmem_ready) begin
            st_q.push_back({dmem_addr, dmem_wdata});
            dmem[dmem_addr[7:2]] <= dmem_wdata;
        end
        if (!dmem_req || dmem_ready) dcnt <= 0;
        else dcnt <= dcnt + 1;
    end

    function automatic logic [31:0] enc_i(input int imm, input int rs1,
                                          input int f3, input int rd,
                                          input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2,
                                          input int rs1, input int f3,
                                          input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2,
                                          input int rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2,
                                          input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3),
                v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        imem[addr[9:2]] = w;
    endtask

    function automatic logic [63:0] st(input int k);
        if (k < st_q.size()) return st_q[k];
        return {64{1'bx}};
    endfunction

    function automatic int rt(input int k);
        if (k < rt_q.size()) return rt_q[k];
        return -1000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        ntest++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_halt(input int maxc);
        for (int i = 0; i < maxc && halted !== 1'b1; i++) @(posedge clk);
        #1;
        chk("halt_reached", 64'(halted), 64'd1);
    endtask

    task automatic start_run();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_req", 64'(imem_req), 64'd1);
        chk("first_addr", 64'(imem_addr), 64'h100);
    endtask

    logic [31:0] ea [10] = '{32'd8, 32'd12, 32'd16, 32'd20, 32'd24,
                             32'd28, 32'd32, 32'd36, 32'd40, 32'd44};
    logic [31:0] ed [10] = '{32'd2, 32'd2, 32'd0, 32'd3, 32'd1, 32'd0,
                             32'h12345000, 32'hF, 32'h15C, 32'hFFFFFFFF};
    int rb, sb, db;

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        put(32'h100, enc_i(5, 0, 0, 1, OP_I));
        put(32'h104, enc_i(-3, 0, 0, 2, OP_I));
        put(32'h108, enc_r(0, 2, 1, 0, 3));
        put(32'h10C, enc_s(8, 3, 0));
        put(32'h110, enc_i(8, 0, 2, 4, OP_L));
        put(32'h114, enc_s(12, 4, 0));
        put(32'h118, enc_i(7, 0, 0, 0, OP_I));
        put(32'h11C, enc_s(16, 0, 0));
        put(32'h120, enc_i(3, 0, 0, 1, OP_I));
        put(32'h124, enc_i(0, 0, 0, 5, OP_I));
        put(32'h128, enc_i(-1, 1, 0, 1, OP_I));
        put(32'h12C, enc_i(1, 5, 0, 5, OP_I));
        put(32'h130, enc_b(-8, 0, 1, 1));
        put(32'h134, enc_s(20, 5, 0));
        put(32'h138, enc_i(-1, 0, 0, 1, OP_I));
        put(32'h13C, enc_i(1, 0, 0, 2, OP_I));
        put(32'h140, enc_r(0, 2, 1, 2, 6));
        put(32'h144, enc_r(0, 2, 1, 3, 7));
        put(32'h148, enc_s(24, 6, 0));
        put(32'h14C, enc_s(28, 7, 0));
        put(32'h150, {20'h12345, 5'd10, 7'b0110111});
        put(32'h154, enc_i(28, 1, 5, 9, OP_I));
        put(32'h158, enc_j(8, 11));
        put(32'h15C, enc_i(0, 0, 0, 10, OP_I));
        put(32'h160, enc_s(32, 10, 0));
        put(32'h164, enc_s(36, 9, 0));
        put(32'h168, enc_s(40, 11, 0));
        put(32'h16C, enc_i(32'h404, 1, 5, 8, OP_I));
        put(32'h170, enc_s(44, 8, 0));
        put(32'h174, 32'h00100073);

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_dmem_req", 64'(dmem_req), 64'd0);
        chk("rst_dmem_we", 64'(dmem_we), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_retire", 64'(retire), 64'd0);
        chk("rst_pc", 64'(imem_addr), 64'h100);

        start_run();
        chk("run_halted", 64'(halted), 64'd0);
        wait_halt(3000);
        chk("ebreak_pc", 64'(imem_addr), 64'h174);
        chk("ebreak_noreq", 64'(imem_req), 64'd0);
        chk("retire_count", 64'(rt_q.size()), 64'd34);
        for (int k = 0; k < 10; k++)
            chk($sformatf("store%0d", k), st(k), {ea[k], ed[k]});
        chk("alu_cpi_a", 64'(rt(1) - rt(0)), 64'd4);
        chk("alu_cpi_b", 64'(rt(2) - rt(1)), 64'd4);
        chk("sw_wait_cpi", 64'(rt(3) - rt(2)), 64'd6);
        chk("lw_wait_cpi", 64'(rt(4) - rt(3)), 64'd7);
        chk("bne_taken_cpi", 64'(rt(12) - rt(11)), 64'd3);
        chk("after_taken", 64'(rt(13) - rt(12)), 64'd4);
        chk("bne_fall_cpi", 64'(rt(18) - rt(17)), 64'd3);
        repeat (5) @(posedge clk);
        #1;
        chk("ebreak_frozen", 64'(imem_addr), 64'h174);
        chk("ebreak_no_retire", 64'(rt_q.size()), 64'd34);

        @(negedge clk);
        rst = 1'b1;
        put(32'h100, 32'h0000007F);
        repeat (2) @(negedge clk);
        db = dreq_cnt;
        start_run();
        wait_halt(50);
        repeat (5) @(posedge clk);
        #1;
        chk("illegal_pc", 64'(imem_addr), 64'h100);
        chk("illegal_no_dreq", 64'(dreq_cnt - db), 64'd0);
        chk("illegal_no_ireq", 64'(imem_req), 64'd0);

        @(negedge clk);
        rst = 1'b1;
        put(32'h100, enc_i(6, 0, 2, 1, OP_L));
        repeat (2) @(negedge clk);
        db = dreq_cnt;
        start_run();
        wait_halt(50);
        repeat (5) @(posedge clk);
        #1;
        chk("misalign_pc", 64'(imem_addr), 64'h100);
        chk("misalign_no_dreq", 64'(dreq_cnt - db), 64'd0);
        chk("misalign_dmem_req", 64'(dmem_req), 64'd0);

        @(negedge clk);
        rst = 1'b1;
        dwait = 50;
        put(32'h100, enc_i(8, 0, 2, 1, OP_L));
        repeat (2) @(negedge clk);
        start_run();
        for (int i = 0; i < 20 && dmem_req !== 1'b1; i++) @(posedge clk);
        @(negedge clk);
        chk("midacc_req", 64'(dmem_req), 64'd1);
        chk("midacc_ready", 64'(dmem_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("midacc_drop", 64'(dmem_req), 64'd0);
        chk("midacc_ireq", 64'(imem_req), 64'd0);
        dwait = 0;
        put(32'h100, enc_i(9, 0, 0, 1, OP_I));
        put(32'h104, enc_s(48, 1, 0));
        put(32'h108, 32'h00000073);
        repeat (2) @(negedge clk);
        rb = rt_q.size();
        sb = st_q.size();
        start_run();
        wait_halt(100);
        chk("restart_store", st(sb), {32'd48, 32'd9});
        chk("restart_retires", 64'(rt_q.size() - rb), 64'd2);
        chk("ecall_pc", 64'(imem_addr), 64'h108);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
